l2_cache_2way: RTL
==================

// Module: l2_cache_2way
// PURPOSE
//  Parametrised 2-way set-associative, write-back, write-allocate L2 line cache between L1 and main memory.
//  Successor to the direct-mapped L2, with the same 128-bit line-granular L1/memory handshakes.
//  Adds per-set LRU replacement, latched requests, and write misses that need no memory read.
//  Moves one full line per transaction.
// PARAMETERS
//  ADDR_W  28   line address width (L1_addr / mem_addr)
//  LINE_W  128  line data width
//  IDX_W   6    set index bits; 2**IDX_W sets x 2 ways; TAG_W = ADDR_W-IDX_W (localparam)
// PORTS
//  clk        in   1       single clock, rising edge
//  n_reset    in   1       reset, asynchronous, active-low
//  L1_read    in   1       L1 read request, held until L1_ready
//  L1_write   in   1       L1 write request (full line), held until L1_ready
//  L1_addr    in   ADDR_W  line address; index = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W]
//  L1_wdata   in   LINE_W  write line
//  L1_ready   out  1       one-cycle completion strobe
//  L1_rdata   out  LINE_W  read line, valid while L1_ready=1
//  mem_read   out  1       memory read request, held until mem_ready
//  mem_write  out  1       memory write request, held until mem_ready
//  mem_addr   out  ADDR_W  memory line address
//  mem_wdata  out  LINE_W  write-back line
//  mem_ready  in   1       memory completion strobe
// BEHAVIOUR
//  Reset (async, n_reset=0): state=IDLE; all valid/dirty/lru bits=0; every output 0; data/tag arrays not reset.
//  Reset mid-transaction: abandons it immediately; mem_read/mem_write drop asynchronously; no array update.
//  Request accepted in IDLE only when L1_read^L1_write=1. Both high or both low: no request, no action.
//  On accept: addr, wdata and op are latched. L1 inputs are ignored until the next IDLE.
//  FSM states: IDLE, WB, FILL, RESP.
//  IDLE, hit (tag match on a valid way):
//    Read: line captured to L1_rdata.
//    Write: line overwritten, dirty=1.
//    LRU set to the other way; ->RESP. Hit latency is 1 cycle (L1_ready in cycle after accept).
//  IDLE, miss: victim = first invalid way (way0 before way1), else way[lru].
//    Victim valid and dirty: ->WB.
//    Otherwise: read ->FILL; write ->install, then RESP.
//  WB: mem_write=1, mem_addr={victim_tag,idx}, mem_wdata=victim line; held stable until mem_ready.
//    Then read ->FILL; write ->install, then RESP.
//  FILL: mem_read=1, mem_addr=latched addr, held until mem_ready.
//    On mem_ready: install mem_rdata (valid=1, dirty=0); L1_rdata=mem_rdata; ->RESP.
//  Write install: victim <= latched wdata, tag, valid=1, dirty=1; no memory read issued.
//  Every hit or install sets lru[idx] to point at the way not used.
//  RESP: L1_ready=1 for exactly one cycle; requests ignored; ->IDLE.
//    L1 drops or changes its request from the next cycle.
//  mem_read and mem_write are never both 1. Memory outputs are 0 outside WB/FILL.
//  L1_rdata holds its last value outside RESP.
// CONFIGURATION
//  L2_STATS_EN defined: adds ports hit_cnt, miss_cnt, wb_cnt (out, 32 each), reset to 0.
//    hit_cnt/miss_cnt +1 per accepted hit/miss; wb_cnt +1 per completed WB. Counters wrap at 2**32.
//  L2_STATS_EN undefined: no counter ports or logic; behaviour otherwise identical.
// TESTING (IDX_W=6, memory returns mem_ready 3 cycles after request)
//  1. Read 0x0000005 after reset -> mem_read with mem_addr 0x0000005; mem_rdata 0xA5..A5 returned;
//     L1_ready 1 cycle with 0xA5..A5. Repeat the read -> L1_ready next cycle, no memory traffic.
//  2. Read 0x0000005, then 0x0000045 (same set) -> two fills, no mem_write. Re-read both -> both hit.
//  3. Write 0x0000005=D1 (no mem_read, dirty). Read 0x0000045 (fills way1). Read 0x0000085 ->
//     mem_write addr 0x0000005 data D1, then mem_read 0x0000085. Read 0x0000045 -> hit.
//  4. L1_read=L1_write=1 for 10 cycles -> L1_ready=0, mem_read=mem_write=0 throughout.
//  5. n_reset low during FILL wait -> mem_read=0 the same cycle. Re-read that address -> miss again.
//  6. With L2_STATS_EN, scenario 3 followed by the final read -> hit_cnt=1, miss_cnt=3, wb_cnt=1.

Source files
------------

// File: rtl/l2_cache_2way_if.sv
// L1/memory line handshake bundle for the 2-way L2 cache.
// slave = cache side, master = L1 + memory side.
interface l2_cache_2way_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              L1_read;
  logic              L1_write;
  logic [ADDR_W-1:0] L1_addr;
  logic [LINE_W-1:0] L1_wdata;
  logic              L1_ready;
  logic [LINE_W-1:0] L1_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  L1_read, L1_write, L1_addr, L1_wdata,
    input  mem_rdata, mem_ready,
    output L1_ready, L1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output L1_read, L1_write, L1_addr, L1_wdata,
    output mem_rdata, mem_ready,
    input  L1_ready, L1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_cache_2way.sv
// 2-way set-associative write-back/write-allocate L2 line cache, per-set LRU.
// Define L2_STATS_EN to add hit_cnt/miss_cnt/wb_cnt counter ports.
module l2_cache_2way #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int IDX_W  = 6
) (
  input logic            clk,
  input logic            n_reset,
  l2_cache_2way_if.slave bus
`ifdef L2_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
  output logic [31:0]    wb_cnt
`endif
);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SETS  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE, WB, FILL, RESP
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_arr  [2][SETS];
  logic [LINE_W-1:0] data_arr [2][SETS];
  logic [1:0]        valid_q  [SETS];
  logic [1:0]        dirty_q  [SETS];
  logic [SETS-1:0]   lru_q;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic              vic_q;
  logic [LINE_W-1:0] rdata_q;

  logic [IDX_W-1:0] in_idx, q_idx;
  logic [TAG_W-1:0] in_tag, q_tag;

  assign in_idx = bus.L1_addr[IDX_W-1:0];
  assign in_tag = bus.L1_addr[ADDR_W-1:IDX_W];
  assign q_idx  = addr_q[IDX_W-1:0];
  assign q_tag  = addr_q[ADDR_W-1:IDX_W];

  logic accept, hit0, hit1, hit, vic, vic_dirty;

  assign accept = (state_q == IDLE)
                & (bus.L1_read ^ bus.L1_write);
  assign hit0 = valid_q[in_idx][0]
              & (tag_arr[0][in_idx] == in_tag);
  assign hit1 = valid_q[in_idx][1]
              & (tag_arr[1][in_idx] == in_tag);
  assign hit  = hit0 | hit1;

  // Invalid ways fill first, way0 before way1.
  always_comb begin
    vic = 1'b0;
    unique case (1'b1)
      !valid_q[in_idx][0]:
        vic = 1'b0;
      valid_q[in_idx][0] & !valid_q[in_idx][1]:
        vic = 1'b1;
      &valid_q[in_idx]:
        vic = lru_q[in_idx];
    endcase
  end

  assign vic_dirty = valid_q[in_idx][vic]
                   & dirty_q[in_idx][vic];

  logic              ins_en;
  logic              ins_way;
  logic [IDX_W-1:0]  ins_idx;
  logic [TAG_W-1:0]  ins_tag;
  logic [LINE_W-1:0] ins_data;
  logic              ins_dirty;
  logic              cap_hit;
  logic              cap_mem;
  logic              wb_done;

  always_comb begin
    state_d   = state_q;
    ins_en    = 1'b0;
    ins_way   = vic_q;
    ins_idx   = q_idx;
    ins_tag   = q_tag;
    ins_data  = wdata_q;
    ins_dirty = 1'b1;
    cap_hit   = 1'b0;
    cap_mem   = 1'b0;
    wb_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ins_idx  = in_idx;
          ins_tag  = in_tag;
          ins_data = bus.L1_wdata;
          if (hit) begin
            ins_way = hit1;
            ins_en  = bus.L1_write;
            cap_hit = bus.L1_read;
            state_d = RESP;
          end else if (vic_dirty) begin
            state_d = WB;
          end else if (bus.L1_read) begin
            state_d = FILL;
          end else begin
            ins_way = vic;
            ins_en  = 1'b1;
            state_d = RESP;
          end
        end
      end
      WB: begin
        if (bus.mem_ready) begin
          wb_done = 1'b1;
          if (wr_q) begin
            ins_en  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ready) begin
          ins_en    = 1'b1;
          ins_data  = bus.mem_rdata;
          ins_dirty = 1'b0;
          cap_mem   = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      lru_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      vic_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.L1_addr;
        wdata_q <= bus.L1_wdata;
        wr_q    <= bus.L1_write;
        vic_q   <= vic;
      end
      if (ins_en) begin
        valid_q[ins_idx][ins_way] <= 1'b1;
        dirty_q[ins_idx][ins_way] <= ins_dirty;
      end
      if (ins_en | cap_hit) begin
        lru_q[ins_idx] <= ~ins_way;
      end
      if (cap_hit) begin
        rdata_q <= data_arr[hit1][in_idx];
      end else if (cap_mem) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Tag/data storage is not reset; block writes while reset is held.
  always_ff @(posedge clk) begin
    if (ins_en && n_reset) begin
      tag_arr[ins_way][ins_idx]  <= ins_tag;
      data_arr[ins_way][ins_idx] <= ins_data;
    end
  end

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      WB: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {tag_arr[vic_q][q_idx], q_idx};
        bus.mem_wdata = data_arr[vic_q][q_idx];
      end
      FILL: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = addr_q;
      end
      default: ;
    endcase
  end

  assign bus.L1_ready = (state_q == RESP);
  assign bus.L1_rdata = rdata_q;

`ifdef L2_STATS_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (accept & hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (accept & !hit) miss_cnt <= miss_cnt + 32'd1;
      if (wb_done)       wb_cnt   <= wb_cnt + 32'd1;
    end
  end
`endif
endmodule
